// File: rtl/matrix_result_unpacker_if.sv
// Stream-side bundle of the matrix result unpacker: packed result matrix in,
// one tagged element per valid/ready handshake out, plus the frame counter.
interface matrix_result_unpacker_if #(
  parameter int data_width = 3,
  parameter int n_columns  = 3,
  parameter int m_rows     = 3
);

  localparam int elem_width = 2 * data_width + $clog2(n_columns);
  localparam int bus_width  = m_rows * n_columns * elem_width;
  localparam int row_width  = (m_rows > 1) ? $clog2(m_rows) : 1;
  localparam int col_width  = (n_columns > 1) ? $clog2(n_columns) : 1;

  logic [bus_width-1:0]  inp;
  logic                  in_valid;
  logic                  in_ready;
  logic [elem_width-1:0] outp;
  logic [row_width-1:0]  out_row;
  logic [col_width-1:0]  out_col;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            frame_cnt;

  // Producer of matrices and consumer of elements
  modport master (
    output inp, in_valid, out_ready,
    input  in_ready, outp, out_row, out_col, out_last, out_valid, frame_cnt
  );

  // The unpacker itself
  modport slave (
    input  inp, in_valid, out_ready,
    output in_ready, outp, out_row, out_col, out_last, out_valid, frame_cnt
  );

endinterface

// File: rtl/matrix_result_unpacker.sv
// Captures a complete packed result matrix into a private register and
// streams it out one element per handshake in row-major order, tagging each
// element with its row/column and a last-of-matrix flag. All outputs are
// registered; inp never reaches the outputs combinationally.
module matrix_result_unpacker #(
  parameter int data_width = 3,
  parameter int n_columns  = 3,
  parameter int m_rows     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_result_unpacker_if.slave  bus
);

  localparam int elem_width = 2 * data_width + $clog2(n_columns);
  localparam int num_elems  = m_rows * n_columns;
  localparam int row_width  = (m_rows > 1) ? $clog2(m_rows) : 1;
  localparam int col_width  = (n_columns > 1) ? $clog2(n_columns) : 1;
  localparam int k_width    = (num_elems > 1) ? $clog2(num_elems) : 1;

  localparam logic [k_width-1:0]   last_idx = k_width'(num_elems - 1);
  localparam logic [col_width-1:0] col_max  = col_width'(n_columns - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                                   state_q, state_d;
  logic [num_elems-1:0][elem_width-1:0]     capture_q, capture_d;
  logic [k_width-1:0]                       k_q, k_d;
  logic [k_width-1:0]                       k_next;
  logic [elem_width-1:0]                    outp_q, outp_d;
  logic [row_width-1:0]                     row_q, row_d;
  logic [col_width-1:0]                     col_q, col_d;
  logic                                     last_q, last_d;
  logic                                     out_valid_q, out_valid_d;
  logic                                     in_ready_q, in_ready_d;
  logic [7:0]                               frame_cnt_q, frame_cnt_d;

  // Next-state logic: capture in IDLE, advance the element index on each
  // accepted transfer in STREAM, and return to IDLE after the last element.
  always_comb begin
    state_d     = state_q;
    capture_d   = capture_q;
    k_d         = k_q;
    k_next      = k_q + k_width'(1);
    outp_d      = outp_q;
    row_d       = row_q;
    col_d       = col_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          capture_d   = bus.inp;
          k_d         = '0;
          outp_d      = bus.inp[elem_width-1:0];
          row_d       = '0;
          col_d       = '0;
          last_d      = (num_elems == 1);
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = STREAM;
        end
      end

      STREAM: begin
        if (out_valid_q && bus.out_ready) begin
          if (last_q) begin
            k_d         = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = IDLE;
          end else begin
            k_d    = k_next;
            outp_d = capture_q[k_next];
            last_d = (k_next == last_idx);
            if (col_q == col_max) begin
              col_d = '0;
              row_d = row_q + row_width'(1);
            end else begin
              col_d = col_q + col_width'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that discards any
  // partially streamed matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      capture_q   <= '0;
      k_q         <= '0;
      outp_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      k_q         <= k_d;
      outp_q      <= outp_d;
      row_q       <= row_d;
      col_q       <= col_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.outp      = outp_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
